// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the datapath load/store interface. Accepts one word read or
//   write at a time, waits WAIT_CYCLES clocks, performs the access and returns
//   a response that is held until the requester takes it.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   req_valid  request present
//   req_ready  responder can accept a request (IDLE only)
//   req_we     1 = write, 0 = read
//   req_addr   byte address, bit 0 ignored
//   req_wdata  write data
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  read data, 0 for writes
//   rsp_err    address error flag
//   busy       request in flight
//
// Build option
//   DMEM_RANGE_CHECK_EN  when defined, word addresses >= DEPTH are flagged
//                        with rsp_err, writes to them are dropped and reads
//                        return 0. When undefined, upper address bits are
//                        ignored and addresses alias modulo DEPTH words.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | ready for a request
// WAIT  | request captured, counting down wait states
// RESP  | response presented, waiting for rsp_ready

module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int IDX_W       = 3,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [14:0] DEPTH_W = 15'(DEPTH);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                cap_we;
  logic [14:0]         cap_waddr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [IDX_W-1:0]    cap_idx;
  logic                addr_oor;
  logic                accept;
  logic                access;

  // Zero at time 0; deliberately not cleared by reset.
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

  assign cap_idx = cap_waddr[IDX_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign addr_oor = (cap_waddr >= DEPTH_W);
  logic unused_bits;
  assign unused_bits = req_addr[0];
`else
  assign addr_oor = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{req_addr[0], cap_waddr};
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_waddr <= '0;
      cap_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_waddr <= req_addr[15:1];
        cap_wdata <= req_wdata;
        cnt       <= WAIT_LD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= addr_oor;
        rsp_rdata <= (cap_we || addr_oor) ? '0 : mem[cap_idx];
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Gated by rst_n so a reset on the access edge abandons the write.
  always_ff @(posedge clk) begin
    if (rst_n && access && cap_we && !addr_oor)
      mem[cap_idx] <= cap_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: every transaction is predicted by a
// plain array model of the word memory plus the latency/handshake rules.
module tb_dmem_responder;

  localparam int DATA_W      = 16;
  localparam int DEPTH       = 8;
  localparam int IDX_W       = 3;
  localparam int WAIT_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [15:0]       req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] mem_m [DEPTH];

  dmem_responder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_oor(input logic [15:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return int'(a >> 1) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic junk_req();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  // One full transaction; hold = cycles of rsp_ready=0 after rsp_valid rises.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int hold, output logic [15:0] rdata_o);
    bit          oor;
    int          idx;
    logic [15:0] exp_rd;
    int          lat;
    oor    = is_oor(addr);
    idx    = int'(addr >> 1) % DEPTH;
    exp_rd = (we || oor) ? 16'h0 : mem_m[idx];
    rdata_o = 16'h0;

    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    @(posedge clk); #1;
    junk_req();
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
      junk_req();
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    chk("latency", lat, WAIT_CYCLES + 1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {31'b0, rsp_valid}, 1);
      chk("hold_rdata", {16'b0, rsp_rdata}, {16'b0, exp_rd});
      chk("hold_req_ready", {31'b0, req_ready}, 0);
      junk_req();
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, exp_rd});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, oor});
    chk("busy_resp", {31'b0, busy}, 1);
    rdata_o = rsp_rdata;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 0);
    chk("busy_idle", {31'b0, busy}, 0);
    chk("req_ready_back", {31'b0, req_ready}, 1);
    if (we && !oor) mem_m[idx] = wdata;
  endtask

  initial begin
    logic [15:0] rd;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // reset held with a request pending
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0; req_wdata = 16'hFFFF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
    end
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'b0, busy}, 0);
    chk("post_rst_ready", {31'b0, req_ready}, 1);

    do_req(1'b0, 16'h0000, 16'h0, 0, rd);
    chk("rst_no_write", {16'b0, rd}, 0);

    do_req(1'b1, 16'h0004, 16'h1234, 0, rd);
    chk("write_rdata0", {16'b0, rd}, 0);
    do_req(1'b0, 16'h0004, 16'h0, 0, rd);
    chk("read_1234", {16'b0, rd}, 32'h1234);
    do_req(1'b0, 16'h0004, 16'h0, 5, rd);
    chk("bp_read_1234", {16'b0, rd}, 32'h1234);

    do_req(1'b1, 16'h0007, 16'hBEEF, 1, rd);
    do_req(1'b0, 16'h0006, 16'h0, 0, rd);
    chk("bit0_ignored", {16'b0, rd}, 32'hBEEF);

    // reset during the second WAIT cycle abandons the write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0002; req_wdata = 16'hFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
    rst_n = 1'b1;
    do_req(1'b0, 16'h0002, 16'h0, 0, rd);
    chk("midrst_old_value", {16'b0, rd}, 0);

    // out-of-range / aliasing
    do_req(1'b1, 16'h0000, 16'h5555, 0, rd);
    do_req(1'b1, 16'h0010, 16'hAAAA, 0, rd);
    do_req(1'b0, 16'h0000, 16'h0, 0, rd);
`ifdef DMEM_RANGE_CHECK_EN
    chk("oor_suppressed", {16'b0, rd}, 32'h5555);
`else
    chk("alias_word0", {16'b0, rd}, 32'hAAAA);
`endif

    for (int t = 0; t < 80; t++) begin
      logic        we;
      logic [15:0] a;
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 31));
      do_req(we, a, 16'($urandom), int'($urandom_range(0, 3)), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
